// File: rtl/tone_arbiter.sv
// Four-requester tone arbiter: grants one tone at a time, drives the sine-table
// phase accumulator, and inserts a silent gap after each tone. Optional preemption
// by a higher-index requester is enabled with macro TONE_ARBITER_PREEMPT_EN.
module tone_arbiter #(
    parameter int unsigned COUNT_SIZE = 8,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned DUR_W      = 16,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned GAP_TICKS  = 2
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    sample_en,
    input  logic [3:0]              req_valid,
    input  logic [4*PHASE_W-1:0]    req_step,
    input  logic [4*DUR_W-1:0]      req_dur,
    output logic [3:0]              req_ack,
    output logic [COUNT_SIZE-1:0]   ADDR,
    output logic                    sound_on,
    output logic [1:0]              active_id,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // A zero-length gap still needs one tick so the down-counter never underflows.
    localparam int unsigned GAP_LOAD = (GAP_TICKS == 0) ? 1 : GAP_TICKS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   step_q, step_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0]     remain_q, remain_d;
    logic [3:0]           ack_q, ack_d;
    logic                 sound_q, sound_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           id_q, id_d;

    logic                 grant_any;
    logic [1:0]           grant_id;
    logic                 load;
    logic                 tick_wrap;
    logic [PHASE_W-1:0]   sel_step;
    logic [DUR_W-1:0]     sel_dur;
`ifdef TONE_ARBITER_PREEMPT_EN
    logic                 pre_any;
`endif

    // Fixed-priority pick: the highest set index wins.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i]) grant_id = 2'(i);
        end
`ifdef TONE_ARBITER_PREEMPT_EN
        pre_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && (2'(i) > id_q)) pre_any = 1'b1;
        end
`endif
    end

    assign sel_step  = req_step[32'(grant_id) * PHASE_W +: PHASE_W];
    assign sel_dur   = req_dur[32'(grant_id) * DUR_W +: DUR_W];
    assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        step_d   = step_q;
        tick_d   = tick_q;
        remain_d = remain_q;
        id_d     = id_q;
        ack_d    = 4'b0000;
        done_d   = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) load = 1'b1;
            end
            PLAY: begin
                if (sample_en) phase_d = phase_q + step_q;
                tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                if (tick_wrap) begin
                    remain_d = remain_q - DUR_W'(1);
                    if (remain_q == DUR_W'(1)) begin
                        state_d  = GAP;
                        phase_d  = '0;
                        remain_d = DUR_W'(GAP_LOAD);
                    end
                end
`ifdef TONE_ARBITER_PREEMPT_EN
                if (pre_any) load = 1'b1;
`endif
            end
            GAP: begin
                phase_d = '0;
                tick_d  = tick_wrap ? '0 : tick_q + TICK_W'(1);
                if (tick_wrap) begin
                    remain_d = remain_q - DUR_W'(1);
                    if (remain_q == DUR_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Grant: latch the winner's parameters and restart the tone from phase 0.
        if (load) begin
            state_d  = PLAY;
            ack_d    = 4'b0001 << grant_id;
            id_d     = grant_id;
            step_d   = sel_step;
            remain_d = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
            phase_d  = '0;
            tick_d   = '0;
        end

        sound_d = (state_d == PLAY);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            step_q   <= '0;
            tick_q   <= '0;
            remain_q <= '0;
            ack_q    <= '0;
            sound_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            remain_q <= remain_d;
            ack_q    <= ack_d;
            sound_q  <= sound_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            id_q     <= id_d;
        end
    end

    assign req_ack   = ack_q;
    assign ADDR      = phase_q[PHASE_W-1 -: COUNT_SIZE];
    assign sound_on  = sound_q;
    assign active_id = id_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
